// File: rtl/clock_pkg.sv
// Shared types and constants for the clock front-end: button FSM states,
// button channel indices and default timing derived from the system clock.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    HELD   = 2'd3
  } btn_state_t;

  localparam int unsigned BTN_INC_MIN  = 0;
  localparam int unsigned BTN_DEC_MIN  = 1;
  localparam int unsigned BTN_INC_HOUR = 2;
  localparam int unsigned BTN_DEC_HOUR = 3;

  localparam int unsigned N_BTN_DEF = 4;

  localparam int unsigned CLK_HZ             = 50_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 50;  // 20 ms
  localparam int unsigned REPEAT_DELAY_DEF    = CLK_HZ / 2;   // 0.5 s
  localparam int unsigned REPEAT_PERIOD_DEF   = CLK_HZ / 5;   // 0.2 s

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, debouncer and press/repeat FSM.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   btn_raw    - raw asynchronous button pin
//   btn_pulse  - one-cycle pulse per press and per auto-repeat (registered)
//   btn_level  - debounced pressed level, 1 = pressed (registered)
module button_channel
  import clock_pkg::*;
#(
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_pulse,
  output logic btn_level
);

  localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned REP_MAX = max_u(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  localparam logic             RAW_RELEASED = (ACTIVE_LOW != 0);
  localparam logic [DEB_W-1:0] DEB_LAST     = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST   = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST  = REP_W'(REPEAT_PERIOD - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             level_q, level_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             pulse_q, pulse_d;
  btn_state_t       state_q, state_d;

  logic pressed_s;
  logic level_rise;
  logic level_fall;

  // Synchroniser and debouncer next-state
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    deb_cnt_d = '0;
    level_d   = level_q;
    pressed_s = sync2_q ^ RAW_RELEASED;
    // A new level must be seen on DEBOUNCE_CYCLES consecutive edges
    if (pressed_s != level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        level_d = ~level_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
    level_rise = level_d & ~level_q;
    level_fall = ~level_d & level_q;
  end

  // State register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= RAW_RELEASED;
      sync2_q   <= RAW_RELEASED;
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
      rep_cnt_q <= '0;
      pulse_q   <= 1'b0;
      state_q   <= IDLE;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
      rep_cnt_q <= rep_cnt_d;
      pulse_q   <= pulse_d;
      state_q   <= state_d;
    end
  end

  // Next-state logic; events are taken from level_d so the press pulse
  // lines up with the first cycle btn_level reads 1
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (level_rise) state_d = (REPEAT_EN != 0) ? DELAY : HELD;
      end
      DELAY: begin
        if (level_fall)                   state_d = IDLE;
        else if (rep_cnt_q == DELAY_LAST) state_d = REPEAT;
      end
      REPEAT: begin
        if (level_fall) state_d = IDLE;
      end
      HELD: begin
        if (level_fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and repeat-counter logic; counter clears at each terminal count
  always_comb begin
    pulse_d   = 1'b0;
    rep_cnt_d = '0;
    unique case (state_q)
      IDLE: begin
        pulse_d = level_rise;
      end
      DELAY: begin
        if (!level_fall) begin
          if (rep_cnt_q == DELAY_LAST) pulse_d = 1'b1;
          else                         rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end
      REPEAT: begin
        if (!level_fall) begin
          if (rep_cnt_q == PERIOD_LAST) pulse_d = 1'b1;
          else                          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end
      HELD: begin
        pulse_d = 1'b0;
      end
      default: begin
        pulse_d = 1'b0;
      end
    endcase
  end

  assign btn_pulse = pulse_q;
  assign btn_level = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the time/alarm-setting push-buttons for the settings controller.
// Ports:
//   clk, rst   - 50 MHz clock, asynchronous active-high reset
//   btn_raw    - raw button pins: [0] inc_min [1] dec_min [2] inc_hour [3] dec_hour
//   btn_pulse  - one-cycle press/repeat pulse per channel
//   btn_level  - debounced pressed level per channel
//   any_held   - OR of btn_level
module button_conditioner
  import clock_pkg::*;
#(
  parameter int unsigned N_BTN           = N_BTN_DEF,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_level,
  output logic             any_held
);

  // Independent channels: no priority or lockout between buttons
  for (genvar g = 0; g < int'(N_BTN); g++) begin : g_ch
    button_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw[g]),
      .btn_pulse (btn_pulse[g]),
      .btn_level (btn_level[g])
    );
  end

  // Derived only from level flops, so still no path from btn_raw
  assign any_held = |btn_level;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
  import clock_pkg::*;

  localparam int unsigned NB  = 4;
  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 10;
  localparam int unsigned RP  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] pulse_a, level_a, pulse_b, level_b;
  logic          any_a, any_b;

  always #5 clk = ~clk;

  button_conditioner #(.N_BTN(NB), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_a (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_pulse(pulse_a), .btn_level(level_a), .any_held(any_a));

  button_conditioner #(.N_BTN(NB), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_b (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_pulse(pulse_b), .btn_level(level_b), .any_held(any_b));

  int total = 0;
  int bad   = 0;
  int t     = 0;

  // Reference model, in "pressed" terms (1 = pressed)
  bit            m_r1   [NB];
  bit            m_r2   [NB];
  bit            m_hist [NB][DEB];
  bit            m_level[NB];
  int            m_rise [NB];
  logic [NB-1:0] m_pulse_a, m_pulse_b, m_level_v;

  function automatic void model_reset();
    for (int ch = 0; ch < int'(NB); ch++) begin
      m_r1[ch] = 0; m_r2[ch] = 0; m_level[ch] = 0; m_rise[ch] = 0;
      for (int i = 0; i < int'(DEB); i++) m_hist[ch][i] = 0;
    end
    m_pulse_a = '0; m_pulse_b = '0; m_level_v = '0;
  endfunction

  // Level flips once the last DEB synchronised samples all disagree with it;
  // repeat pulses fall at RD after the press and every RP after that.
  function automatic void model_edge(input logic [NB-1:0] raw);
    for (int ch = 0; ch < int'(NB); ch++) begin
      bit all_diff, new_level, pa, pb;
      int d;
      for (int i = int'(DEB) - 1; i > 0; i--) m_hist[ch][i] = m_hist[ch][i-1];
      m_hist[ch][0] = m_r2[ch];
      all_diff = 1;
      for (int i = 0; i < int'(DEB); i++) if (m_hist[ch][i] == m_level[ch]) all_diff = 0;
      new_level = all_diff ? ~m_level[ch] : m_level[ch];
      pa = 0; pb = 0;
      if (new_level && !m_level[ch]) begin
        m_rise[ch] = t; pa = 1; pb = 1;
      end else if (new_level && m_level[ch]) begin
        d = t - m_rise[ch];
        if (d == int'(RD) || (d > int'(RD) && ((d - int'(RD)) % int'(RP)) == 0)) pa = 1;
      end
      m_level[ch]   = new_level;
      m_r2[ch]      = m_r1[ch];
      m_r1[ch]      = ~raw[ch];
      m_pulse_a[ch] = pa;
      m_pulse_b[ch] = pb;
      m_level_v[ch] = new_level;
    end
  endfunction

  task automatic chk4(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d act=%b exp=%b", name, t, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0d act=%0d exp=%0d", name, t, act, exp);
    end
  endtask

  // One clock edge, model update, then compare both DUTs against the model
  task automatic step();
    @(posedge clk);
    t++;
    if (rst) model_reset();
    else     model_edge(btn_raw);
    #1;
    chk4("pulse_a", pulse_a, m_pulse_a);
    chk4("level_a", level_a, m_level_v);
    chk4("any_a",   NB'(any_a), NB'(|m_level_v));
    chk4("pulse_b", pulse_b, m_pulse_b);
    chk4("level_b", level_b, m_level_v);
    chk4("any_b",   NB'(any_b), NB'(|m_level_v));
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    model_reset();
    #1;
    chk4("rst_pulse", pulse_a | pulse_b, '0);
    chk4("rst_level", level_a | level_b, '0);
    chk4("rst_any",   NB'(any_a | any_b), '0);
  endtask

  typedef struct {
    logic [NB-1:0] raw;
    logic [NB-1:0] pulse;
    logic [NB-1:0] level;
  } vec_t;

  vec_t tbl[20];
  int   qa[$];
  int   qb[$];
  int   exp_rep[6];
  int   first, early, late;
  int   hold[NB];
  logic [NB-1:0] acc;

  initial begin
    exp_rep = '{6, 16, 19, 22, 25, 28};
    for (int c = 0; c < 20; c++) begin
      tbl[c].raw   = (c < 8) ? 4'b1110 : 4'b1111;
      tbl[c].pulse = (c == 6) ? 4'b0001 : 4'b0000;
      tbl[c].level = (c >= 6 && c < 14) ? 4'b0001 : 4'b0000;
    end

    // Reset state
    rst = 1'b1;
    btn_raw = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk4("reset_pulse", pulse_a | pulse_b, '0);
    chk4("reset_level", level_a | level_b, '0);
    chk4("reset_any",   NB'(any_a | any_b), '0);
    rst = 1'b0;

    // All released: silence for 50 cycles
    acc = '0;
    for (int c = 0; c < 50; c++) begin
      step();
      acc = acc | pulse_a | pulse_b | level_a;
    end
    chk4("idle_quiet", acc, '0);

    // Single clean press of inc_min, table-driven
    for (int c = 0; c < 20; c++) begin
      step();
      chk4("tbl_pulse", pulse_a, tbl[c].pulse);
      chk4("tbl_level", level_a, tbl[c].level);
      chk4("tbl_pulse_b", pulse_b, tbl[c].pulse);
      btn_raw = tbl[c].raw;
    end
    repeat (5) step();

    // Bounce on dec_min, then stable low from c=20
    first = -1; early = 0;
    for (int c = 0; c < 32; c++) begin
      step();
      if (pulse_a[BTN_DEC_MIN]) begin
        if (first < 0) first = c;
        if (c < 26) early++;
      end
      btn_raw[BTN_DEC_MIN] = (c < 20) ? 1'((c / 2) % 2) : 1'b0;
    end
    chki("bounce_early", early, 0);
    chki("bounce_first", first, 26);
    btn_raw = '1;
    repeat (12) step();

    // Auto-repeat on inc_hour: held for 30 cycles, then released
    late = 0;
    for (int c = 0; c < 46; c++) begin
      step();
      if (c < 30 && pulse_a[BTN_INC_HOUR]) qa.push_back(c);
      if (c < 30 && pulse_b[BTN_INC_HOUR]) qb.push_back(c);
      if (c >= 36 && (pulse_a[BTN_INC_HOUR] || pulse_b[BTN_INC_HOUR])) late++;
      btn_raw[BTN_INC_HOUR] = (c < 30) ? 1'b0 : 1'b1;
    end
    chki("rep_count", qa.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < qa.size()) chki("rep_cycle", qa[i], exp_rep[i]);
    chki("norep_count", qb.size(), 1);
    if (qb.size() > 0) chki("norep_cycle", qb[0], 6);
    chki("rep_after_release", late, 0);
    repeat (5) step();

    // Simultaneous inc_min + dec_hour
    for (int c = 0; c < 24; c++) begin
      step();
      if (c == 6)  chk4("simul_pulse", pulse_a, 4'b1001);
      if (c == 18) chk4("simul_any_one", NB'(any_a), 4'b0001);
      if (c == 20) chk4("simul_any_last", NB'(any_a), 4'b0001);
      if (c == 21) chk4("simul_any_off", NB'(any_a), 4'b0000);
      if (c == 0)        btn_raw = 4'b0110;
      else if (c == 10)  btn_raw[BTN_INC_MIN] = 1'b1;
      else if (c == 15)  btn_raw[BTN_DEC_HOUR] = 1'b1;
    end
    repeat (5) step();

    // Reset in the middle of a press
    first = -1; early = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (pulse_a[BTN_INC_MIN]) begin
        if (first < 0) first = c;
        if (c < 11) early++;
      end
      if (c == 0) btn_raw[BTN_INC_MIN] = 1'b0;
      if (c == 3) assert_rst();
      if (c == 5) rst = 1'b0;
    end
    chki("rst_early", early, 0);
    chki("rst_first", first, 11);
    btn_raw = '1;
    repeat (10) step();

    // Randomised holds and occasional resets against the model
    for (int ch = 0; ch < int'(NB); ch++) hold[ch] = 0;
    for (int c = 0; c < 1500; c++) begin
      step();
      for (int ch = 0; ch < int'(NB); ch++) begin
        if (hold[ch] == 0) begin
          btn_raw[ch] = 1'($urandom_range(0, 1));
          hold[ch] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                 : int'($urandom_range(4, 30));
        end else begin
          hold[ch]--;
        end
      end
      if ($urandom_range(0, 249) == 0) assert_rst();
      else rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
